// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and overflow helper for the multi-cycle ALU.
package alu_pkg;

  localparam int unsigned OP_AND = 0;
  localparam int unsigned OP_OR  = 1;
  localparam int unsigned OP_ADD = 2;
  localparam int unsigned OP_SUB = 6;
  localparam int unsigned OP_SLT = 7;
  localparam int unsigned OP_MUL = 8;
  localparam int unsigned OP_NOR = 12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Two's-complement overflow: effective operand signs agree but the result sign flips.
  // For subtraction pass the inverted sign of the subtrahend.
  function automatic logic sign_ovf(input logic sa, input logic sb_eff, input logic sr);
    return (sa == sb_eff) && (sr != sa);
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Operand/result valid-ready bundle for alu_mc; ovf_o exists only when ALU_OVF_EN is defined.
interface alu_mc_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CTRL_W = 4
);

  logic              in_valid_i;
  logic              in_ready_o;
  logic [WIDTH-1:0]  src1_i;
  logic [WIDTH-1:0]  src2_i;
  logic [CTRL_W-1:0] ctrl_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [WIDTH-1:0]  result_o;
`ifdef ALU_OVF_EN
  logic              ovf_o;

  modport master (
    output in_valid_i, src1_i, src2_i, ctrl_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, ovf_o
  );

  modport slave (
    input  in_valid_i, src1_i, src2_i, ctrl_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, ovf_o
  );
`else
  modport master (
    output in_valid_i, src1_i, src2_i, ctrl_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o
  );

  modport slave (
    input  in_valid_i, src1_i, src2_i, ctrl_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o
  );
`endif

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle for exactly WIDTH cycles.
// ACC_W > WIDTH keeps the upper product bits for overflow detection.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ACC_W = WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_c,
  output logic [ACC_W-1:0] acc_next_c
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [ACC_W-1:0] mcand_q, mcand_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;

  // Next-state: load on start, otherwise one shift-add step per cycle while running.
  always_comb begin
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    last_c   = 1'b0;
    if (start_i) begin
      mcand_d  = ACC_W'(a_i);
      mplier_d = b_i;
      acc_d    = '0;
      cnt_d    = CNT_W'(WIDTH);
      run_d    = 1'b1;
    end else if (run_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        run_d  = 1'b0;
        last_c = 1'b1;
      end
    end
    acc_next_c = acc_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes, registered result and fixed-latency MUL.
// Define ALU_OVF_EN to add the registered ovf_o flag and widen the multiplier accumulator.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CTRL_W = 4
) (
  input  logic    clk_i,
  input  logic    rst_i,
  alu_mc_if.slave bus
);

`ifdef ALU_OVF_EN
  localparam int unsigned ACC_W = 2 * WIDTH;
`else
  localparam int unsigned ACC_W = WIDTH;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] a_c, b_c;
  logic [WIDTH-1:0] sum_c, diff_c, alu_c;
  logic             is_mul_c;
  logic             mul_start_c;
  logic             mul_last_c;
  logic [ACC_W-1:0] mul_acc_c;

  assign a_c      = bus.src1_i;
  assign b_c      = bus.src2_i;
  assign sum_c    = a_c + b_c;
  assign diff_c   = a_c - b_c;
  assign is_mul_c = (bus.ctrl_i == CTRL_W'(OP_MUL));

  // Single-cycle operations; unknown codes yield zero.
  always_comb begin
    alu_c = '0;
    case (bus.ctrl_i)
      CTRL_W'(OP_AND): alu_c = a_c & b_c;
      CTRL_W'(OP_OR):  alu_c = a_c | b_c;
      CTRL_W'(OP_ADD): alu_c = sum_c;
      CTRL_W'(OP_SUB): alu_c = diff_c;
      CTRL_W'(OP_SLT): alu_c = (a_c < b_c) ? WIDTH'(1) : '0;
      CTRL_W'(OP_NOR): alu_c = ~(a_c | b_c);
      default:         alu_c = '0;
    endcase
  end

`ifdef ALU_OVF_EN
  logic ovf_q, ovf_d;
  logic ovf_c;

  always_comb begin
    ovf_c = 1'b0;
    case (bus.ctrl_i)
      CTRL_W'(OP_ADD): ovf_c = sign_ovf(a_c[WIDTH-1], b_c[WIDTH-1], sum_c[WIDTH-1]);
      CTRL_W'(OP_SUB): ovf_c = sign_ovf(a_c[WIDTH-1], ~b_c[WIDTH-1], diff_c[WIDTH-1]);
      default:         ovf_c = 1'b0;
    endcase
  end

  assign bus.ovf_o = ovf_q;
`endif

  alu_mul_iter #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W)
  ) u_mul (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (mul_start_c),
    .a_i        (a_c),
    .b_i        (b_c),
    .last_c     (mul_last_c),
    .acc_next_c (mul_acc_c)
  );

  // Control FSM: IDLE accepts, MUL waits on the iterator, DONE holds until the consumer takes it.
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    mul_start_c = 1'b0;
`ifdef ALU_OVF_EN
    ovf_d       = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid_i) begin
          if (is_mul_c) begin
            mul_start_c = 1'b1;
            state_d     = S_MUL;
          end else begin
            result_d    = alu_c;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
`ifdef ALU_OVF_EN
            ovf_d       = ovf_c;
`endif
          end
        end
      end
      S_MUL: begin
        if (mul_last_c) begin
          result_d    = mul_acc_c[WIDTH-1:0];
          out_valid_d = 1'b1;
          state_d     = S_DONE;
`ifdef ALU_OVF_EN
          ovf_d       = |mul_acc_c[ACC_W-1:WIDTH];
`endif
        end
      end
      S_DONE: begin
        if (bus.out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      out_valid_q <= 1'b0;
`ifdef ALU_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
`ifdef ALU_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  // Ready is a decode of the state flop, gated off asynchronously during reset.
  assign bus.in_ready_o  = (state_q == S_IDLE) && !rst_i;
  assign bus.out_valid_o = out_valid_q;
  assign bus.result_o    = result_q;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed vector table, multi-cycle corner sequences and
// randomized regression at WIDTH=8 and WIDTH=32 against an arithmetic reference model.
module tb_alu_mc;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_mc_if #(.WIDTH(32), .CTRL_W(4)) bus32();
  alu_mc_if #(.WIDTH(8),  .CTRL_W(4)) bus8();

  alu_mc #(.WIDTH(32), .CTRL_W(4)) dut32 (.clk_i(clk), .rst_i(rst), .bus(bus32));
  alu_mc #(.WIDTH(8),  .CTRL_W(4)) dut8  (.clk_i(clk), .rst_i(rst), .bus(bus8));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        o;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input int w, input bit v, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] c);
    if (w == 8) begin
      bus8.in_valid_i = v; bus8.src1_i = a[7:0]; bus8.src2_i = b[7:0]; bus8.ctrl_i = c;
    end else begin
      bus32.in_valid_i = v; bus32.src1_i = a; bus32.src2_i = b; bus32.ctrl_i = c;
    end
  endtask

  task automatic set_ordy(input int w, input bit r);
    if (w == 8) bus8.out_ready_i = r;
    else        bus32.out_ready_i = r;
  endtask

  function automatic bit rdy(input int w);
    return (w == 8) ? bus8.in_ready_o : bus32.in_ready_o;
  endfunction

  function automatic bit ovalid(input int w);
    return (w == 8) ? bus8.out_valid_o : bus32.out_valid_o;
  endfunction

  function automatic logic [31:0] res(input int w);
    return (w == 8) ? 32'(bus8.result_o) : bus32.result_o;
  endfunction

  function automatic logic ovf(input int w);
`ifdef ALU_OVF_EN
    return (w == 8) ? bus8.ovf_o : bus32.ovf_o;
`else
    return (w == 8) ? 1'b0 : 1'b0;
`endif
  endfunction

  // Reference model: plain wide arithmetic, truncated to w bits.
  function automatic logic [31:0] model(input int w, input logic [3:0] c, input logic [31:0] a,
                                        input logic [31:0] b, output logic o);
    logic [63:0] m, ua, ub, p;
    longint sa, sb, s, maxs, mins;
    m    = (64'd1 << w) - 64'd1;
    ua   = 64'(a) & m;
    ub   = 64'(b) & m;
    maxs = (longint'(1) <<< (w - 1)) - 1;
    mins = -(longint'(1) <<< (w - 1));
    sa   = ua[w-1] ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
    sb   = ub[w-1] ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
    o    = 1'b0;
    case (c)
      4'd0:  p = ua & ub;
      4'd1:  p = ua | ub;
      4'd2:  begin p = ua + ub; s = sa + sb; o = (s > maxs) || (s < mins); end
      4'd6:  begin p = ua - ub; s = sa - sb; o = (s > maxs) || (s < mins); end
      4'd7:  p = (ua < ub) ? 64'd1 : 64'd0;
      4'd8:  begin p = ua * ub; o = (p > m); end
      4'd12: p = ~(ua | ub);
      default: p = 64'd0;
    endcase
    return 32'(p & m);
  endfunction

  // Issue one op on an idle DUT with out_ready held high; report result and latency.
  task automatic run_op(input int w, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic o, output int lat, output bit leak);
    int guard = 0;
    while (!rdy(w) && guard < 100) begin tick(); guard++; end
    chk("ready_before_issue", 64'(rdy(w)), 64'd1);
    drive_in(w, 1'b1, a, b, c);
    tick();
    drive_in(w, 1'b0, $urandom, $urandom, 4'($urandom));
    lat  = 1;
    leak = 1'b0;
    while (!ovalid(w) && lat < 200) begin
      if (rdy(w)) leak = 1'b1;
      tick();
      lat++;
    end
    if (rdy(w)) leak = 1'b1;
    r = res(w);
    o = ovf(w);
    tick();
  endtask

  function automatic logic [31:0] rand_opnd(input int w);
    logic [31:0] mask, one;
    mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    one  = 32'd1;
    case ($urandom_range(0, 4))
      0: return mask;
      1: return 32'($urandom_range(0, 3));
      2: return one << (w - 1);
      3: return (one << (w - 1)) - 32'd1;
      default: return $urandom & mask;
    endcase
  endfunction

  function automatic logic [3:0] pick_code();
    case ($urandom_range(0, 9))
      0: return 4'd0;
      1: return 4'd1;
      2: return 4'd2;
      3: return 4'd6;
      4: return 4'd7;
      5, 6: return 4'd8;
      7: return 4'd12;
      8: return 4'd5;
      default: return 4'd15;
    endcase
  endfunction

  // Random ops with random producer gaps and consumer stalls; results must come out in order.
  task automatic rand_run(input int w, input int n_ops);
    logic [31:0] exp_r[$];
    logic        exp_o[$];
    logic [31:0] pa = '0, pb = '0, er;
    logic [3:0]  pc = '0;
    logic        eo, mo;
    bit          pend = 1'b0, ordy;
    int          issued = 0, got = 0, cyc = 0;
    while ((issued < n_ops || pend || exp_r.size() != 0) && cyc < 20000) begin
      if (!pend && issued < n_ops && $urandom_range(0, 9) < 6) begin
        pend = 1'b1;
        pa   = rand_opnd(w);
        pb   = rand_opnd(w);
        pc   = pick_code();
      end
      drive_in(w, pend, pa, pb, pc);
      ordy = ($urandom_range(0, 9) < 7);
      set_ordy(w, ordy);
      if (ovalid(w)) begin
        if (exp_r.size() == 0) begin
          chk($sformatf("rand%0d_spurious_valid", w), 64'd1, 64'd0);
        end else if (ordy) begin
          er = exp_r.pop_front();
          eo = exp_o.pop_front();
          chk($sformatf("rand%0d_result_%0d", w, got), 64'(res(w)), 64'(er));
`ifdef ALU_OVF_EN
          chk($sformatf("rand%0d_ovf_%0d", w, got), 64'(ovf(w)), 64'(eo));
`endif
          got++;
        end
      end
      if (pend && rdy(w)) begin
        exp_r.push_back(model(w, pc, pa, pb, mo));
        exp_o.push_back(mo);
        pend = 1'b0;
        issued++;
      end
      tick();
      cyc++;
    end
    chk($sformatf("rand%0d_no_timeout", w), 64'(cyc < 20000), 64'd1);
    chk($sformatf("rand%0d_result_count", w), 64'(got), 64'(n_ops));
    drive_in(w, 1'b0, '0, '0, '0);
    set_ordy(w, 1'b1);
  endtask

  initial begin
    vec_t        vt[$];
    logic [31:0] r;
    logic        o;
    int          lat;
    bit          leak, seen;

    rst = 1'b1;
    drive_in(32, 1'b0, '0, '0, '0);
    drive_in(8,  1'b0, '0, '0, '0);
    set_ordy(32, 1'b1);
    set_ordy(8,  1'b1);

    // Reset state
    #12;
    chk("rst_in_ready", 64'(rdy(32)), 64'd0);
    chk("rst_out_valid", 64'(ovalid(32)), 64'd0);
    chk("rst_result", 64'(res(32)), 64'd0);
    chk("rst_ovf", 64'(ovf(32)), 64'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 64'(rdy(32)), 64'd1);
    chk("rel_in_ready8", 64'(rdy(8)), 64'd1);
    tick();

    vt.push_back('{4'd2,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0});
    vt.push_back('{4'd6,  32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0});
    vt.push_back('{4'd7,  32'd3,         32'hFFFF_FFFF, 32'd1,         1'b0});
    vt.push_back('{4'd7,  32'hFFFF_FFFF, 32'd3,         32'd0,         1'b0});
    vt.push_back('{4'd12, 32'd0,         32'd0,         32'hFFFF_FFFF, 1'b0});
    vt.push_back('{4'd5,  32'h1234_5678, 32'h9ABC_DEF0, 32'd0,         1'b0});
    vt.push_back('{4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         1'b0});
    vt.push_back('{4'd0,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0});
    vt.push_back('{4'd1,  32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0});
    vt.push_back('{4'd8,  32'd1234,      32'd5678,      32'd7006652,   1'b0});
    vt.push_back('{4'd2,  32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 1'b1});
    vt.push_back('{4'd6,  32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1'b1});
    vt.push_back('{4'd8,  32'h0001_0000, 32'h0001_0000, 32'd0,         1'b1});
    vt.push_back('{4'd2,  32'd2,         32'd2,         32'd4,         1'b0});
    vt.push_back('{4'd8,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         1'b1});

    foreach (vt[i]) begin
      run_op(32, vt[i].c, vt[i].a, vt[i].b, r, o, lat, leak);
      chk($sformatf("vec%0d_result", i), 64'(r), 64'(vt[i].r));
      chk($sformatf("vec%0d_latency", i), 64'(lat), (vt[i].c == 4'd8) ? 64'd33 : 64'd1);
      chk($sformatf("vec%0d_ready_low", i), 64'(leak), 64'd0);
`ifdef ALU_OVF_EN
      chk($sformatf("vec%0d_ovf", i), 64'(o), 64'(vt[i].o));
`endif
    end

    // Backpressure: result held through a 10-cycle stall while a new request waits
    set_ordy(32, 1'b0);
    drive_in(32, 1'b1, 32'h0000_F0F0, 32'h0000_FF00, 4'd0);
    tick();
    drive_in(32, 1'b1, 32'd1, 32'd1, 4'd2);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("bp_valid_%0d", k), 64'(ovalid(32)), 64'd1);
      chk($sformatf("bp_result_%0d", k), 64'(res(32)), 64'h0000_F000);
      chk($sformatf("bp_ready_%0d", k), 64'(rdy(32)), 64'd0);
      tick();
    end
    set_ordy(32, 1'b1);
    tick();
    chk("bp_after_hs_valid", 64'(ovalid(32)), 64'd0);
    chk("bp_after_hs_ready", 64'(rdy(32)), 64'd1);
    tick();
    drive_in(32, 1'b0, '0, '0, '0);
    chk("bp_next_valid", 64'(ovalid(32)), 64'd1);
    chk("bp_next_result", 64'(res(32)), 64'd2);
    tick();

    // Asynchronous reset in the middle of a MUL
    drive_in(32, 1'b1, 32'd7, 32'd9, 4'd8);
    tick();
    drive_in(32, 1'b0, '0, '0, '0);
    repeat (5) tick();
    chk("mul_busy_valid", 64'(ovalid(32)), 64'd0);
    chk("mul_busy_ready", 64'(rdy(32)), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(ovalid(32)), 64'd0);
    chk("midrst_result", 64'(res(32)), 64'd0);
    chk("midrst_ready", 64'(rdy(32)), 64'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("midrst_rel_ready", 64'(rdy(32)), 64'd1);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (ovalid(32)) seen = 1'b1;
      tick();
    end
    chk("midrst_no_stale", 64'(seen), 64'd0);

    rand_run(32, 150);
    rand_run(8, 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the single-cycle combinational ALU in the MIPS datapath.
- Operand width is configurable.
- Inputs and outputs use valid/ready handshakes, and the result is registered.
- MUL is an iterative shift-add multiply with fixed latency, so a hazard/stall unit can stall the EX stage on a known cycle count.

Parameters:
- WIDTH, 32, operand and result width in bits (minimum 4).
- CTRL_W, 4, operation-select width.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- in_valid_i  in  1  operands and ctrl are valid.
- in_ready_o  out  1  block can accept an operation.
- src1_i  in  WIDTH  operand A.
- src2_i  in  WIDTH  operand B.
- ctrl_i  in  CTRL_W  operation select.
- out_valid_o  out  1  result_o is valid.
- out_ready_i  in  1  consumer takes the result.
- result_o  out  WIDTH  registered result.
- ovf_o  out  1  overflow flag; present only with ALU_OVF_EN.

Behaviour:
- Reset (rst_i high, asynchronous):
  - state=IDLE, out_valid_o=0, result_o=0, ovf_o=0, internal counters and accumulator cleared.
  - in_ready_o is forced to 0 while rst_i is high.
  - Reset mid-operation aborts the operation; nothing is output.
- Ctrl codes:
  - 0 AND; 1 OR; 2 ADD; 6 SUB (src1-src2); 7 SLT; 8 MUL; 12 NOR.
  - SLT is unsigned: 1 if src1<src2, else 0, zero-extended to WIDTH.
  - Any other code gives result 0 with single-cycle latency; it is not an error.
- Arithmetic wraps modulo 2^WIDTH. MUL returns the low WIDTH bits of the unsigned product.
- Accept: on a clock edge with in_valid_i and in_ready_o both high, src1_i, src2_i and ctrl_i are captured. Input changes after accept are ignored.
- State IDLE:
  - in_ready_o=1, out_valid_o=0.
  - Accept with ctrl≠8: result computed and registered on the accept edge; go to DONE. out_valid_o is high the cycle after accept (latency 1).
  - Accept with ctrl=8: load multiplicand=src1, multiplier=src2, acc=0, count=WIDTH; go to MUL.
- State MUL:
  - in_ready_o=0, out_valid_o=0.
  - Each cycle: if multiplier[0], acc+=multiplicand; multiplicand<<=1; multiplier>>=1; count-=1.
  - When count reaches 0, result_o<=acc and go to DONE.
  - Exactly WIDTH cycles in MUL with no early exit. out_valid_o rises WIDTH+1 cycles after the accept edge.
- State DONE:
  - in_ready_o=0, out_valid_o=1.
  - result_o (and ovf_o) are held stable until out_valid_o && out_ready_i at a clock edge; then go to IDLE.
  - Backpressure of any length is held indefinitely.
- Throughput: at most one operation every 2 cycles. No accept is possible in DONE even if out_ready_i is high in the same cycle.
- Simultaneous in_valid_i in DONE or MUL: ignored, not queued. The producer must hold its request.
- out_valid_o never deasserts without a handshake, except on reset.

Optional Feature:
- Macro ALU_OVF_EN.
- Defined: ovf_o exists, registered alongside result_o, and reset to 0.
  - ADD: signed overflow (operands have the same sign and the result sign differs).
  - SUB: signed overflow (operands have different signs and the result sign differs from src1).
  - MUL: 1 if the unsigned product ≥ 2^WIDTH. The accumulator widens to 2*WIDTH bits to support this.
  - All other ops: 0.
- Undefined: ovf_o port absent; accumulator is WIDTH bits; behaviour otherwise identical.

Decomposition:
- Package alu_pkg:
  - opcode localparams OP_AND=0, OP_OR=1, OP_ADD=2, OP_SUB=6, OP_SLT=7, OP_MUL=8, OP_NOR=12.
  - FSM state encoding S_IDLE, S_MUL, S_DONE.
- Sub-module alu_mul_iter: shift-add multiplier datapath (operand registers, accumulator, counter, done pulse), parametrised by WIDTH.
- The FSM and single-cycle ops stay in the top level.

Test Plan:
- Reset: rst_i pulsed mid-cycle while in MUL → out_valid_o=0 and result_o=0 immediately (asynchronous); in_ready_o=1 after release; no stale result is ever output.
- Single-cycle ops, WIDTH=32, out_ready_i=1, 2-cycle spacing:
  - ADD 0xFFFFFFFF+1 → 0x0, out_valid_o one cycle after accept.
  - SUB 5-7 → 0xFFFFFFFE.
  - SLT 3,0xFFFFFFFF → 1.
  - NOR 0,0 → 0xFFFFFFFF.
  - ctrl=5 → 0.
- MUL 1234×5678 → 7006652. out_valid_o rises exactly 33 cycles after the accept edge; in_ready_o=0 for the whole interval.
- Backpressure: out_ready_i=0 for 10 cycles after an AND 0xF0F0,0xFF00 → result_o=0xF000 held stable and out_valid_o=1 throughout; a new in_valid_i is not accepted until the cycle after the handshake.
- With ALU_OVF_EN:
  - ADD 0x7FFFFFFF+1 → ovf_o=1.
  - SUB 0x80000000-1 → ovf_o=1.
  - MUL 0x10000×0x10000 → result 0, ovf_o=1.
  - ADD 2+2 → ovf_o=0.
- Random regression, WIDTH=8 and 32: random ops and random ready stalls vs. a reference model; every accepted op yields exactly one result, in order.
